// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler: N-write / M-read burst port scheduler.
// Writes beat reads; fixed or round-robin arbitration within each class.
module sdram_port_scheduler #(
  parameter int NWR     = 2,
  parameter int NRD     = 2,
  parameter int ASIZE   = 23,
  parameter int LSIZE   = 8,
  parameter int RR_MODE = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NWR*LSIZE-1:0] wr_level,
  input  logic [NWR-1:0]       wr_load,
  input  logic [NWR*ASIZE-1:0] wr_base,
  input  logic [NWR*ASIZE-1:0] wr_max,
  input  logic [NWR*LSIZE-1:0] wr_len,
  input  logic [NRD*LSIZE-1:0] rd_level,
  input  logic [NRD-1:0]       rd_load,
  input  logic [NRD*ASIZE-1:0] rd_base,
  input  logic [NRD*ASIZE-1:0] rd_max,
  input  logic [NRD*LSIZE-1:0] rd_len,
  output logic                 req_valid,
  output logic                 req_write,
  output logic [ASIZE-1:0]     req_addr,
  output logic [LSIZE-1:0]     req_len,
  input  logic                 req_ack,
  input  logic                 req_done,
  output logic [NWR-1:0]       wr_mask,
  output logic [NRD-1:0]       rd_mask,
  output logic                 busy
);

  localparam int WIW = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int RIW = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int AW1 = ASIZE + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BURST,
    UPDATE
  } state_t;

  state_t state_q;

  logic             req_valid_q;
  logic             req_write_q;
  logic [ASIZE-1:0] req_addr_q;
  logic [LSIZE-1:0] req_len_q;
  logic [NWR-1:0]   wr_mask_q;
  logic [NRD-1:0]   rd_mask_q;

  logic [ASIZE-1:0] wptr_q [NWR];
  logic [ASIZE-1:0] rptr_q [NRD];

  logic [WIW-1:0] wrr_q, wgnt_q, wr_sel, wrr_d;
  logic [RIW-1:0] rrr_q, rgnt_q, rd_sel, rrr_d;

  logic [NWR-1:0] wr_elig;
  logic [NRD-1:0] rd_elig;
  logic           wr_any, rd_any;

  logic ld_hit_q;
  logic gnt_load;
  logic do_adv;

  int wstart, rstart, widx, ridx;

  logic [ASIZE-1:0] cur_ptr, cur_base, cur_max, adv_ptr;
  logic [AW1-1:0]   sum;

  always_comb begin
    wr_elig = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_elig[i] = (wr_len[i*LSIZE +: LSIZE] != '0)
                && (wr_level[i*LSIZE +: LSIZE] >= wr_len[i*LSIZE +: LSIZE])
                && !wr_load[i];
    end
    rd_elig = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_elig[j] = (rd_len[j*LSIZE +: LSIZE] != '0)
                && (rd_level[j*LSIZE +: LSIZE] < rd_len[j*LSIZE +: LSIZE])
                && !rd_load[j];
    end
  end

  // First eligible port searching upward from the class start, wrapping
  always_comb begin
    wr_any = 1'b0;
    wr_sel = '0;
    widx   = 0;
    wstart = (RR_MODE != 0) ? int'(wrr_q) : 0;
    for (int k = 0; k < NWR; k++) begin
      widx = (wstart + k) % NWR;
      if (!wr_any && wr_elig[widx]) begin
        wr_any = 1'b1;
        wr_sel = WIW'(widx);
      end
    end
  end

  always_comb begin
    rd_any = 1'b0;
    rd_sel = '0;
    ridx   = 0;
    rstart = (RR_MODE != 0) ? int'(rrr_q) : 0;
    for (int k = 0; k < NRD; k++) begin
      ridx = (rstart + k) % NRD;
      if (!rd_any && rd_elig[ridx]) begin
        rd_any = 1'b1;
        rd_sel = RIW'(ridx);
      end
    end
  end

  assign wrr_d = (wgnt_q == WIW'(NWR - 1)) ? '0 : wgnt_q + 1'b1;
  assign rrr_d = (rgnt_q == RIW'(NRD - 1)) ? '0 : rgnt_q + 1'b1;

  assign gnt_load = req_write_q ? wr_load[wgnt_q] : rd_load[rgnt_q];

  always_comb begin
    if (req_write_q) begin
      cur_ptr  = wptr_q[wgnt_q];
      cur_base = wr_base[int'(wgnt_q)*ASIZE +: ASIZE];
      cur_max  = wr_max[int'(wgnt_q)*ASIZE +: ASIZE];
    end else begin
      cur_ptr  = rptr_q[rgnt_q];
      cur_base = rd_base[int'(rgnt_q)*ASIZE +: ASIZE];
      cur_max  = rd_max[int'(rgnt_q)*ASIZE +: ASIZE];
    end
    sum     = {1'b0, cur_ptr} + AW1'(req_len_q);
    adv_ptr = (sum < {1'b0, cur_max}) ? sum[ASIZE-1:0] : cur_base;
  end

  // A load seen on the granted port mid-burst leaves its pointer at base
  assign do_adv = (state_q == UPDATE) && !ld_hit_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      wr_mask_q   <= '0;
      rd_mask_q   <= '0;
      wrr_q       <= '0;
      rrr_q       <= '0;
      wgnt_q      <= '0;
      rgnt_q      <= '0;
      ld_hit_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ld_hit_q <= 1'b0;
          if (wr_any) begin
            req_valid_q <= 1'b1;
            req_write_q <= 1'b1;
            req_addr_q  <= wptr_q[wr_sel];
            req_len_q   <= wr_len[int'(wr_sel)*LSIZE +: LSIZE];
            wr_mask_q   <= NWR'(1) << wr_sel;
            wgnt_q      <= wr_sel;
            state_q     <= ISSUE;
          end else if (rd_any) begin
            req_valid_q <= 1'b1;
            req_write_q <= 1'b0;
            req_addr_q  <= rptr_q[rd_sel];
            req_len_q   <= rd_len[int'(rd_sel)*LSIZE +: LSIZE];
            rd_mask_q   <= NRD'(1) << rd_sel;
            rgnt_q      <= rd_sel;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (gnt_load) ld_hit_q <= 1'b1;
          if (req_ack) begin
            req_valid_q <= 1'b0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (gnt_load) ld_hit_q <= 1'b1;
          if (req_done) begin
            wr_mask_q <= '0;
            rd_mask_q <= '0;
            state_q   <= UPDATE;
          end
        end
        UPDATE: begin
          if (RR_MODE != 0) begin
            if (req_write_q) wrr_q <= wrr_d;
            else             rrr_q <= rrr_d;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NWR; i++) wptr_q[i] <= '0;
      for (int j = 0; j < NRD; j++) rptr_q[j] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_load[i])
          wptr_q[i] <= wr_base[i*ASIZE +: ASIZE];
        else if (do_adv && req_write_q && wgnt_q == WIW'(i))
          wptr_q[i] <= adv_ptr;
      end
      for (int j = 0; j < NRD; j++) begin
        if (rd_load[j])
          rptr_q[j] <= rd_base[j*ASIZE +: ASIZE];
        else if (do_adv && !req_write_q && rgnt_q == RIW'(j))
          rptr_q[j] <= adv_ptr;
      end
    end
  end

  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_len   = req_len_q;
  assign wr_mask   = wr_mask_q;
  assign rd_mask   = rd_mask_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// tb_sdram_port_scheduler: fixed-priority and round-robin instances,
// table-driven bursts with a scoreboard queue plus corner sequences.
module tb_sdram_port_scheduler;

  localparam int NW = 2;
  localparam int NR = 3;
  localparam int AS = 23;
  localparam int LS = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  logic [NW*LS-1:0] wr_level, wr_len;
  logic [NW-1:0]    wr_load;
  logic [NW*AS-1:0] wr_base, wr_max;
  logic [NR*LS-1:0] rd_level, rd_len;
  logic [NR-1:0]    rd_load;
  logic [NR*AS-1:0] rd_base, rd_max;

  logic [1:0]    vld, wrt, ack, done, bsy;
  logic [AS-1:0] addr [2];
  logic [LS-1:0] lenq [2];
  logic [NW-1:0] wm [2];
  logic [NR-1:0] rm [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          w;
    int          p;
    logic [22:0] a;
    logic [7:0]  l;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    int          d;
    logic [1:0]  w;
    logic [2:0]  r;
    int          ackd;
    bit          spur;
    bit          ew;
    int          ep;
    logic [22:0] ea;
  } vec_t;

  vec_t tbl [18];

  sdram_port_scheduler #(
    .NWR(NW), .NRD(NR), .ASIZE(AS), .LSIZE(LS), .RR_MODE(0)
  ) u_fix (
    .CLK(CLK), .RESET_N(RESET_N),
    .wr_level(wr_level), .wr_load(wr_load),
    .wr_base(wr_base), .wr_max(wr_max), .wr_len(wr_len),
    .rd_level(rd_level), .rd_load(rd_load),
    .rd_base(rd_base), .rd_max(rd_max), .rd_len(rd_len),
    .req_valid(vld[0]), .req_write(wrt[0]),
    .req_addr(addr[0]), .req_len(lenq[0]),
    .req_ack(ack[0]), .req_done(done[0]),
    .wr_mask(wm[0]), .rd_mask(rm[0]), .busy(bsy[0])
  );

  sdram_port_scheduler #(
    .NWR(NW), .NRD(NR), .ASIZE(AS), .LSIZE(LS), .RR_MODE(1)
  ) u_rr (
    .CLK(CLK), .RESET_N(RESET_N),
    .wr_level(wr_level), .wr_load(wr_load),
    .wr_base(wr_base), .wr_max(wr_max), .wr_len(wr_len),
    .rd_level(rd_level), .rd_load(rd_load),
    .rd_base(rd_base), .rd_max(rd_max), .rd_len(rd_len),
    .req_valid(vld[1]), .req_write(wrt[1]),
    .req_addr(addr[1]), .req_len(lenq[1]),
    .req_ack(ack[1]), .req_done(done[1]),
    .wr_mask(wm[1]), .rd_mask(rm[1]), .busy(bsy[1])
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic set_dem(input logic [1:0] w, input logic [2:0] r);
    for (int i = 0; i < NW; i++)
      wr_level[i*LS +: LS] = w[i] ? 8'd8 : 8'd0;
    for (int j = 0; j < NR; j++)
      rd_level[j*LS +: LS] = r[j] ? 8'd0 : 8'd8;
  endtask

  task automatic push(input bit w, input int p, input logic [22:0] a,
                      input logic [7:0] l);
    exp_t e;
    e.w = w;
    e.p = p;
    e.a = a;
    e.l = l;
    sbq.push_back(e);
  endtask

  task automatic reset_and_load();
    @(negedge CLK);
    RESET_N = 1'b0;
    ack = '0;
    done = '0;
    wr_load = '0;
    rd_load = '0;
    set_dem(2'b00, 3'b000);
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(vld[d]), 32'd0);
      chk("rst_write", 32'(wrt[d]), 32'd0);
      chk("rst_addr", 32'(addr[d]), 32'd0);
      chk("rst_len", 32'(lenq[d]), 32'd0);
      chk("rst_wmask", 32'(wm[d]), 32'd0);
      chk("rst_rmask", 32'(rm[d]), 32'd0);
      chk("rst_busy", 32'(bsy[d]), 32'd0);
    end
    RESET_N = 1'b1;
    wr_load = '1;
    rd_load = '1;
    @(negedge CLK);
    wr_load = '0;
    rd_load = '0;
    sbq.delete();
  endtask

  task automatic burst(input int d, input int ackd, input bit spur,
                       input logic [1:0] ldw, input bit ldclr);
    exp_t e;
    int n;
    logic [31:0] ewm, erm;
    n = 0;
    while (vld[d] !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (vld[d] !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: dut%0d req_valid=%b required 1", d, vld[d]);
      if (sbq.size() != 0) e = sbq.pop_front();
      return;
    end
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    ewm = e.w ? (32'd1 << e.p) : 32'd0;
    erm = e.w ? 32'd0 : (32'd1 << e.p);
    chk("req_write", 32'(wrt[d]), 32'(e.w));
    chk("req_addr", 32'(addr[d]), 32'(e.a));
    chk("req_len", 32'(lenq[d]), 32'(e.l));
    chk("wr_mask", 32'(wm[d]), ewm);
    chk("rd_mask", 32'(rm[d]), erm);
    for (int h = 0; h < ackd; h++) begin
      if (h == 0 && spur) done[d] = 1'b1;
      @(negedge CLK);
      done[d] = 1'b0;
      chk("hold_valid", 32'(vld[d]), 32'd1);
      chk("hold_addr", 32'(addr[d]), 32'(e.a));
      chk("hold_len", 32'(lenq[d]), 32'(e.l));
    end
    ack[d] = 1'b1;
    @(negedge CLK);
    ack[d] = 1'b0;
    chk("burst_valid_low", 32'(vld[d]), 32'd0);
    if (ldw != '0) wr_load = wr_load | ldw;
    repeat (2) @(negedge CLK);
    if (ldclr) wr_load = wr_load & ~ldw;
    chk("burst_wmask", 32'(wm[d]), ewm);
    chk("burst_rmask", 32'(rm[d]), erm);
    done[d] = 1'b1;
    @(negedge CLK);
    done[d] = 1'b0;
    chk("upd_masks", 32'({wm[d], rm[d]}), 32'd0);
    chk("upd_busy", 32'(bsy[d]), 32'd1);
    @(negedge CLK);
  endtask

  initial begin
    int prev_d;
    int n;
    ack = '0;
    done = '0;
    wr_load = '0;
    rd_load = '0;
    wr_base = {23'h2000, 23'h1000};
    wr_max  = {23'h2018, 23'h1018};
    wr_len  = {8'd8, 8'd8};
    rd_base = {23'h5000, 23'h4000, 23'h3000};
    rd_max  = {23'h5018, 23'h4018, 23'h3018};
    rd_len  = {8'd8, 8'd8, 8'd8};
    set_dem(2'b00, 3'b000);

    // d, wr demand, rd demand, ack delay, spurious done, exp w/port/addr
    tbl[0]  = '{0, 2'b11, 3'b000, 0, 1'b0, 1'b1, 0, 23'h1000};
    tbl[1]  = '{0, 2'b11, 3'b000, 0, 1'b0, 1'b1, 0, 23'h1008};
    tbl[2]  = '{0, 2'b10, 3'b000, 2, 1'b0, 1'b1, 1, 23'h2000};
    tbl[3]  = '{0, 2'b00, 3'b110, 0, 1'b0, 1'b0, 1, 23'h4000};
    tbl[4]  = '{0, 2'b00, 3'b111, 0, 1'b0, 1'b0, 0, 23'h3000};
    tbl[5]  = '{1, 2'b11, 3'b000, 5, 1'b1, 1'b1, 0, 23'h1000};
    tbl[6]  = '{1, 2'b11, 3'b000, 0, 1'b0, 1'b1, 1, 23'h2000};
    tbl[7]  = '{1, 2'b11, 3'b000, 0, 1'b0, 1'b1, 0, 23'h1008};
    tbl[8]  = '{1, 2'b11, 3'b000, 0, 1'b0, 1'b1, 1, 23'h2008};
    tbl[9]  = '{1, 2'b00, 3'b111, 0, 1'b0, 1'b0, 0, 23'h3000};
    tbl[10] = '{1, 2'b00, 3'b111, 1, 1'b0, 1'b0, 1, 23'h4000};
    tbl[11] = '{1, 2'b00, 3'b111, 0, 1'b0, 1'b0, 2, 23'h5000};
    tbl[12] = '{1, 2'b00, 3'b111, 0, 1'b0, 1'b0, 0, 23'h3008};
    tbl[13] = '{1, 2'b01, 3'b111, 0, 1'b0, 1'b1, 0, 23'h1010};
    tbl[14] = '{1, 2'b01, 3'b000, 0, 1'b0, 1'b1, 0, 23'h1000};
    tbl[15] = '{1, 2'b10, 3'b000, 0, 1'b0, 1'b1, 1, 23'h2010};
    tbl[16] = '{1, 2'b00, 3'b010, 0, 1'b0, 1'b0, 1, 23'h4008};
    tbl[17] = '{1, 2'b00, 3'b001, 0, 1'b0, 1'b0, 0, 23'h3010};

    prev_d = -1;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].d != prev_d) reset_and_load();
      prev_d = tbl[i].d;
      set_dem(tbl[i].w, tbl[i].r);
      push(tbl[i].ew, tbl[i].ep, tbl[i].ea, 8'd8);
      burst(tbl[i].d, tbl[i].ackd, tbl[i].spur, 2'b00, 1'b0);
    end

    // Load isolation and load on the granted port mid-burst
    reset_and_load();
    set_dem(2'b11, 3'b000);
    push(1'b1, 0, 23'h1000, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);
    push(1'b1, 1, 23'h2000, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);
    push(1'b1, 0, 23'h1008, 8'd8);
    burst(1, 0, 1'b0, 2'b10, 1'b0);
    push(1'b1, 0, 23'h1010, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);
    wr_load = '0;
    push(1'b1, 1, 23'h2000, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);
    push(1'b1, 0, 23'h1000, 8'd8);
    burst(1, 0, 1'b0, 2'b01, 1'b1);
    push(1'b1, 1, 23'h2008, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);
    push(1'b1, 0, 23'h1000, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);

    // Asynchronous reset while in BURST
    reset_and_load();
    set_dem(2'b01, 3'b000);
    n = 0;
    while (vld[1] !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("ar_valid_seen", 32'(vld[1]), 32'd1);
    ack[1] = 1'b1;
    @(negedge CLK);
    ack[1] = 1'b0;
    chk("ar_busy_pre", 32'(bsy[1]), 32'd1);
    chk("ar_wmask_pre", 32'(wm[1]), 32'd1);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("ar_valid", 32'(vld[1]), 32'd0);
    chk("ar_wmask", 32'(wm[1]), 32'd0);
    chk("ar_busy", 32'(bsy[1]), 32'd0);
    chk("ar_addr", 32'(addr[1]), 32'd0);
    reset_and_load();
    set_dem(2'b01, 3'b000);
    push(1'b1, 0, 23'h1000, 8'd8);
    burst(1, 0, 1'b0, 2'b00, 1'b0);

    // Wrap: base 0x100, max 0x120, len 0x10
    reset_and_load();
    wr_base[0 +: AS] = 23'h100;
    wr_max[0 +: AS]  = 23'h120;
    wr_len[0 +: LS]  = 8'h10;
    wr_load = 2'b01;
    @(negedge CLK);
    wr_load = '0;
    wr_level = {8'h00, 8'h10};
    push(1'b1, 0, 23'h100, 8'h10);
    push(1'b1, 0, 23'h110, 8'h10);
    push(1'b1, 0, 23'h100, 8'h10);
    for (int b = 0; b < 3; b++) burst(1, 0, 1'b0, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
